// File: rtl/pipelined_shifter_if.sv
// Valid/ready bundle between the operand mux and the pipelined shifter.
// master drives operations and consumes results; slave is the shifter.
interface pipelined_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int LOG2W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LOG2W-1:0] in_shamt;
    logic [2:0]       in_ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_shamt, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_ctrl, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Logarithmic shift/rotate unit, registered every REG_EVERY levels,
// with a valid/ready handshake and full backpressure.
module pipelined_shifter #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 1
) (
    input logic               clk,
    input logic               rst,
    pipelined_shifter_if.slave bus
);
    localparam int LOG2W = $clog2(WIDTH);
    localparam int LAT   = (LOG2W + REG_EVERY - 1) / REG_EVERY;

    typedef struct packed {
        logic             v;
        logic [2:0]       op;
        logic [LOG2W-1:0] sa;
        logic [WIDTH-1:0] d;
    } stage_t;

    stage_t         st  [LAT];
    stage_t         nx  [LAT];
    logic [LAT-1:0] adv;

    function automatic logic [WIDTH-1:0] lvl(
        input logic [WIDTH-1:0] x,
        input logic [2:0]       op,
        input int               s
    );
        logic [WIDTH-1:0] r;
        r = x;
        case (op)
            3'b000:  r = x << s;
            3'b001:  r = x >> s;
            3'b011:  r = $unsigned($signed(x) >>> s);
            3'b100:  r = (x << s) | (x >> (WIDTH - s));
            3'b101:  r = (x >> s) | (x << (WIDTH - s));
            default: r = x;
        endcase
        return r;
    endfunction

    // Applies only the levels [lo, hi) owned by one stage.
    function automatic logic [WIDTH-1:0] run(
        input logic [WIDTH-1:0] x,
        input logic [2:0]       op,
        input logic [LOG2W-1:0] sa,
        input int               lo,
        input int               hi
    );
        logic [WIDTH-1:0] r;
        r = x;
        for (int k = 0; k < LOG2W; k++) begin
            if (k >= lo && k < hi && sa[k]) begin
                r = lvl(r, op, 1 << k);
            end
        end
        return r;
    endfunction

    // Stage i may move when empty or when everything after it moves.
    always_comb begin
        logic a;
        adv = '0;
        a   = bus.out_ready;
        for (int i = LAT - 1; i >= 0; i--) begin
            a      = ~st[i].v | a;
            adv[i] = a;
        end
    end

    always_comb begin
        stage_t src;
        stage_t inp;
        nx  = '{default: '0};
        inp = '{v:  bus.in_valid,
                op: bus.in_ctrl,
                sa: bus.in_shamt,
                d:  bus.in_data};
        src = inp;
        for (int i = 0; i < LAT; i++) begin
            src = (i == 0) ? inp : st[(i == 0) ? 0 : i - 1];
            nx[i]   = src;
            nx[i].d = run(src.d, src.op, src.sa,
                          i * REG_EVERY, (i + 1) * REG_EVERY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                st[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LAT; i++) begin
                if (adv[i]) begin
                    st[i] <= nx[i];
                end
            end
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = st[LAT-1].v;
    assign bus.out_data  = st[LAT-1].d;
endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed checks of the pipelined shifter in a 32/1 and a 16/2 build.
// Inputs driven and outputs sampled on the falling edge.
module tb_pipelined_shifter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nmis = 0;

    always #5 clk = ~clk;

    pipelined_shifter_if #(.WIDTH(32)) b32 ();
    pipelined_shifter_if #(.WIDTH(16)) b16 ();

    pipelined_shifter #(.WIDTH(32), .REG_EVERY(1)) u32 (
        .clk(clk), .rst(rst), .bus(b32)
    );
    pipelined_shifter #(.WIDTH(16), .REG_EVERY(2)) u16 (
        .clk(clk), .rst(rst), .bus(b16)
    );

    task automatic drive32(input logic [2:0] c, input logic [31:0] x,
                           input logic [4:0] s);
        b32.in_valid = 1'b1;
        b32.in_ctrl  = c;
        b32.in_data  = x;
        b32.in_shamt = s;
        #1;
    endtask

    task automatic apply32(input string nm, input logic [2:0] c,
                           input logic [31:0] x, input logic [4:0] s,
                           input logic [31:0] e);
        int lat;
        @(negedge clk);
        drive32(c, x, s);
        nvec++;
        if (b32.in_ready !== 1'b1) begin
            nmis++;
            $display("FAIL %s in_ready got %b want 1", nm, b32.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        b32.in_valid = 1'b0;
        lat = 1;
        while (b32.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        nvec++;
        if (lat != 5) begin
            nmis++;
            $display("FAIL %s latency got %0d want 5", nm, lat);
        end
        nvec++;
        if (b32.out_data !== e) begin
            nmis++;
            $display("FAIL %s data got %h want %h", nm, b32.out_data, e);
        end
    endtask

    task automatic apply16(input string nm, input logic [2:0] c,
                           input logic [15:0] x, input logic [3:0] s,
                           input logic [15:0] e);
        int lat;
        @(negedge clk);
        b16.in_valid = 1'b1;
        b16.in_ctrl  = c;
        b16.in_data  = x;
        b16.in_shamt = s;
        #1;
        nvec++;
        if (b16.in_ready !== 1'b1) begin
            nmis++;
            $display("FAIL %s in_ready got %b want 1", nm, b16.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        b16.in_valid = 1'b0;
        lat = 1;
        while (b16.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        nvec++;
        if (lat != 2) begin
            nmis++;
            $display("FAIL %s latency got %0d want 2", nm, lat);
        end
        nvec++;
        if (b16.out_data !== e) begin
            nmis++;
            $display("FAIL %s data got %h want %h", nm, b16.out_data, e);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++;
        if (b32.out_valid !== 1'b0 || b32.out_data !== 32'h0) begin
            nmis++;
            $display("FAIL reset32 out got v=%b d=%h want v=0 d=0",
                     b32.out_valid, b32.out_data);
        end
        nvec++;
        if (b32.in_ready !== 1'b1) begin
            nmis++;
            $display("FAIL reset32 in_ready got %b want 1", b32.in_ready);
        end
        nvec++;
        if (b16.out_valid !== 1'b0 || b16.out_data !== 16'h0) begin
            nmis++;
            $display("FAIL reset16 out got v=%b d=%h want v=0 d=0",
                     b16.out_valid, b16.out_data);
        end
    endtask

    task automatic test_shifts;
        apply32("sra4",  3'b011, 32'h8000_0000, 5'd4,  32'hF800_0000);
        apply32("srl4",  3'b001, 32'h8000_0000, 5'd4,  32'h0800_0000);
        apply32("sra31", 3'b011, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        apply32("sll31", 3'b000, 32'h0000_0001, 5'd31, 32'h8000_0000);
        apply32("sll0",  3'b000, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5);
        apply32("sra0",  3'b011, 32'h8765_4321, 5'd0,  32'h8765_4321);
    endtask

    task automatic test_rotates;
        apply32("ror8",  3'b101, 32'h1234_5678, 5'd8,  32'h7812_3456);
        apply32("rol1",  3'b100, 32'h8000_0001, 5'd1,  32'h0000_0003);
        apply32("rol31", 3'b100, 32'h8000_0001, 5'd31, 32'hC000_0000);
        apply32("ror0",  3'b101, 32'h1234_5678, 5'd0,  32'h1234_5678);
    endtask

    task automatic test_passthru;
        apply32("pass010", 3'b010, 32'hCAFE_F00D, 5'd7,  32'hCAFE_F00D);
        apply32("pass110", 3'b110, 32'h0123_4567, 5'd19, 32'h0123_4567);
        apply32("pass111", 3'b111, 32'hFFFF_0000, 5'd31, 32'hFFFF_0000);
    endtask

    task automatic test_back_to_back;
        logic [2:0]  c [8];
        logic [31:0] x [8];
        logic [4:0]  s [8];
        logic [31:0] e [8];
        c = '{3'b000, 3'b001, 3'b011, 3'b100,
              3'b101, 3'b110, 3'b000, 3'b011};
        x = '{32'h0000_0001, 32'hF000_0000, 32'hF000_0000, 32'h1234_5678,
              32'h1234_5678, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        s = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd3, 5'd16, 5'd30};
        e = '{32'h0000_0010, 32'h0F00_0000, 32'hFF00_0000, 32'h2345_6781,
              32'h8123_4567, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'h0000_0001};
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            nvec++;
            if (t >= 5 && t <= 12) begin
                if (b32.out_valid !== 1'b1 || b32.out_data !== e[t-5]) begin
                    nmis++;
                    $display("FAIL b2b cycle %0d got v=%b d=%h want v=1 d=%h",
                             t, b32.out_valid, b32.out_data, e[t-5]);
                end
            end else if (b32.out_valid !== 1'b0) begin
                nmis++;
                $display("FAIL b2b cycle %0d out_valid got %b want 0",
                         t, b32.out_valid);
            end
            if (t < 8) begin
                drive32(c[t], x[t], s[t]);
                nvec++;
                if (b32.in_ready !== 1'b1) begin
                    nmis++;
                    $display("FAIL b2b in_ready cycle %0d got %b want 1",
                             t, b32.in_ready);
                end
            end else begin
                b32.in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] e [6];
        int          n;
        logic        acc;
        for (int k = 0; k < 6; k++) e[k] = 32'h1 << k;
        @(negedge clk);
        b32.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            drive32(3'b100, 32'h1, 5'(k));
            nvec++;
            if (b32.in_ready !== 1'b1) begin
                nmis++;
                $display("FAIL bp fill %0d in_ready got %b want 1",
                         k, b32.in_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        drive32(3'b100, 32'h1, 5'd5);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            nvec++;
            if (b32.in_ready !== 1'b0) begin
                nmis++;
                $display("FAIL bp stall %0d in_ready got %b want 0",
                         c, b32.in_ready);
            end
            nvec++;
            if (b32.out_valid !== 1'b1 || b32.out_data !== e[0]) begin
                nmis++;
                $display("FAIL bp hold %0d got v=%b d=%h want v=1 d=%h",
                         c, b32.out_valid, b32.out_data, e[0]);
            end
        end
        @(negedge clk);
        b32.out_ready = 1'b1;
        #1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (b32.out_valid === 1'b1) begin
                nvec++;
                if (n >= 6) begin
                    nmis++;
                    $display("FAIL bp drain extra got %h want none",
                             b32.out_data);
                end else if (b32.out_data !== e[n]) begin
                    nmis++;
                    $display("FAIL bp drain %0d got %h want %h",
                             n, b32.out_data, e[n]);
                end
                n++;
            end
            acc = b32.in_valid & b32.in_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) b32.in_valid = 1'b0;
        end
        nvec++;
        if (n != 6) begin
            nmis++;
            $display("FAIL bp drain count got %0d want 6", n);
        end
    endtask

    task automatic test_reset_midflight;
        logic bad;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive32(3'b000, 32'h1, 5'(k));
            @(posedge clk);
        end
        @(negedge clk);
        drive32(3'b000, 32'h3, 5'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        b32.in_valid = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (b32.out_valid !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        nvec++;
        if (bad) begin
            nmis++;
            $display("FAIL rst32 flush out_valid got 1 want 0");
        end
        apply32("rst32 next", 3'b101, 32'h0000_00FF, 5'd4, 32'hF000_000F);
    endtask

    task automatic test_w16;
        logic bad;
        apply16("w16 sra15", 3'b011, 16'h8000, 4'd15, 16'hFFFF);
        apply16("w16 rol1",  3'b100, 16'h8001, 4'd1,  16'h0003);
        apply16("w16 ror5",  3'b101, 16'h1234, 4'd5,  16'hA091);
        apply16("w16 sll15", 3'b000, 16'h0001, 4'd15, 16'h8000);
        @(negedge clk);
        b16.in_valid = 1'b1;
        b16.in_ctrl  = 3'b001;
        b16.in_data  = 16'hFFFF;
        b16.in_shamt = 4'd1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        b16.in_valid = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (b16.out_valid !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        nvec++;
        if (bad) begin
            nmis++;
            $display("FAIL rst16 flush out_valid got 1 want 0");
        end
        apply16("w16 after rst", 3'b011, 16'h8000, 4'd15, 16'hFFFF);
    endtask

    initial begin
        b32.in_valid  = 1'b0;
        b32.in_ctrl   = 3'b000;
        b32.in_data   = '0;
        b32.in_shamt  = '0;
        b32.out_ready = 1'b1;
        b16.in_valid  = 1'b0;
        b16.in_ctrl   = 3'b000;
        b16.in_data   = '0;
        b16.in_shamt  = '0;
        b16.out_ready = 1'b1;
        test_reset();
        test_shifts();
        test_rotates();
        test_passthru();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_w16();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
Parametrised, pipelined successor to the ALU's single-cycle barrel shifter. It is generalised in data width and pipeline depth, adds rotate modes, and uses a valid/ready handshake with full backpressure. It sits between the execute-stage operand mux and the result writeback path for multi-cycle ALU operation, accepting one shift per cycle at full throughput.

Parameters:
WIDTH, 32, data width in bits; must be a power of 2, minimum 4
REG_EVERY, 1, number of shift levels per pipeline register; range 1..LOG2W
LOG2W (localparam), $clog2(WIDTH), number of shift levels and shift-amount width
LAT (localparam), ceil(LOG2W/REG_EVERY), pipeline latency in cycles

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input operation valid
in_ready  output  1  block can accept an input this cycle
in_data  input  WIDTH  operand to be shifted
in_shamt  input  LOG2W  shift amount, unsigned
in_ctrl  input  3  operation select
out_valid  output  1  out_data holds a completed result
out_ready  input  1  consumer accepts the result this cycle
out_data  output  WIDTH  shifted result

Behaviour:
- Operation encoding in in_ctrl:
  - 000: SLL, zero fill.
  - 001: SRL, zero fill.
  - 011: SRA, sign-bit fill, operand treated as signed.
  - 100: ROL.
  - 101: ROR.
  - 010, 110, 111: pass-through, out_data = in_data.
- Shift structure: logarithmic. Level k (k = 0..LOG2W-1) shifts or rotates by 2^k when in_shamt[k] = 1, otherwise passes its input unchanged.
- Shift amount 0: output equals input for every mode.
- Shift amount WIDTH-1 (maximum):
  - SLL leaves only bit 0 of the input, moved to the MSB.
  - SRA yields all copies of the sign bit.
  - ROL by WIDTH-1 equals ROR by 1.
- Each operation's ctrl and remaining shamt bits travel with its data through the pipeline. Different operations may occupy different stages simultaneously.
- Pipeline: LAT register stages, S0..S(LAT-1). A register follows every REG_EVERY levels; the final register may cover fewer levels.
  - The output is registered: out_data and out_valid come directly from S(LAT-1).
  - Latency: an input accepted in cycle N appears with out_valid = 1 in cycle N+LAT, provided no stall occurs.
- Handshake:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - Stage i advances when it is empty or stage i+1 advances. The last stage advances when out_ready = 1 or it is empty.
  - in_ready = stage 0 advances. Combinational paths from out_ready to in_ready are permitted.
  - Throughput is one operation per cycle when out_ready is held at 1.
  - A stalled stage holds its data and valid bit unchanged; no result is lost or duplicated.
  - out_data is stable while out_valid = 1 and out_ready = 0.
  - A bubble (in_valid = 0 while in_ready = 1) propagates as an invalid stage. Bubbles are compressed when a downstream stage is stalled.
  - Simultaneous input transfer and output transfer on a full pipeline is legal; occupancy is unchanged.
- Reset:
  - All stage valid bits clear to 0, so out_valid = 0. out_data clears to 0. All stage data registers clear to 0.
  - in_ready = 1 in the first cycle after reset is released.
  - Reset asserted mid-operation discards every in-flight operation with no output. Inputs presented during reset are not accepted.
- Only the listed operations are defined; no X may reach out_data for any in_ctrl value.

Test Plan:
Unless stated otherwise: WIDTH=32, REG_EVERY=1 (LAT=5), and out_ready = 1.
- SRA: in_data=0x80000000, shamt=4, ctrl=011 accepted at cycle 0 -> out_valid=1 with out_data=0xF8000000 at cycle 5. SRL with the same operands -> 0x08000000.
- Rotates: ROR 0x12345678 by 8 -> 0x78123456. ROL 0x80000001 by 1 -> 0x00000003. SLL 0x00000001 by 31 -> 0x80000000. ctrl=010 with shamt=7 -> data unchanged.
- Back-to-back throughput: 8 consecutive ops in cycles 0..7 -> results in cycles 5..12, in order, one per cycle, in_ready constantly 1.
- Backpressure: fill the pipe, then hold out_ready=0 for 3 cycles:
  - in_ready=0 after the pipe is full.
  - out_data is held steady.
  - On release, all ops drain in order with no loss or duplication.
- Reset mid-flight: assert rst for 1 cycle with 3 ops in flight -> out_valid stays 0 afterwards and the next accepted op returns after exactly 5 cycles. Repeat with WIDTH=16, REG_EVERY=2 (LAT=2): SRA 0x8000 by 15 -> 0xFFFF at cycle 2.
